// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the adder-tree arbiter.
//   arb_state_e : arbiter FSM states
//   acc_width   : accumulator width for a given lane count, lane width and beat budget
//   rr_pick     : cyclic first-valid search starting at a pointer
package adder_tree_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} arb_state_e;

  // Upper bound on requester count handled by rr_pick.
  localparam int unsigned MAX_R   = 32;
  localparam int unsigned MAX_R_W = 5;

  function automatic int unsigned acc_width(input int unsigned n, input int unsigned w,
                                            input int unsigned beats_w);
    return w + unsigned'($clog2(n)) + beats_w;
  endfunction

  // Returns the first index at or after ptr (mod nreq) whose valid bit is set.
  // Scans from the far end so the nearest hit is the last assignment.
  function automatic int unsigned rr_pick(input logic [MAX_R-1:0] valid,
                                          input int unsigned ptr, input int unsigned nreq);
    int unsigned idx;
    int unsigned pick;
    pick = ptr;
    for (int i = int'(MAX_R) - 1; i >= 0; i--) begin
      idx = ptr + unsigned'(i);
      if (idx >= nreq) idx = idx - nreq;
      if ((unsigned'(i) < nreq) && valid[idx[MAX_R_W-1:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_tree.sv
// Combinational reduction of N unsigned lanes into one W+clog2(N)-bit sum.
//   lanes : N lanes of W bits
//   sum_c : unsigned sum of all lanes (combinational)
module adder_tree #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 16
) (
  input  logic [N-1:0][W-1:0]         lanes,
  output logic [W+$clog2(N)-1:0]      sum_c
);

  localparam int unsigned SW = W + $clog2(N);

  // Widen each lane before adding; SW is sized so the total never wraps.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_c = sum_c + SW'(lanes[i]);
    end
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin time-sharing of one adder tree among R beat-streaming requesters.
// A whole transaction is granted at a time; per-beat tree sums are accumulated
// and returned as one scalar tagged with the requester id.
//   clk, reset_n            : clock, async active-low reset
//   req_valid/ready/last[R] : per-requester beat handshake and end-of-transaction
//   req_data[R][N]          : per-requester beat lanes
//   res_valid/res_ready     : result handshake
//   res_sum/res_id/res_ovf  : accumulated sum, owner id, beat-budget overflow
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 16,
  parameter int unsigned R       = 4,
  parameter int unsigned BEATS_W = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [R-1:0]                        req_valid,
  output logic [R-1:0]                        req_ready,
  input  logic [R-1:0][N-1:0][W-1:0]          req_data,
  input  logic [R-1:0]                        req_last,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [acc_width(N, W, BEATS_W)-1:0] res_sum,
  output logic [$clog2(R)-1:0]                res_id,
  output logic                                res_ovf
);

  localparam int unsigned D     = $clog2(N);
  localparam int unsigned ACC_W = acc_width(N, W, BEATS_W);
  localparam int unsigned IDW   = $clog2(R);
  localparam int unsigned TW    = W + D;
  localparam int unsigned CNT_W = BEATS_W + 1;
  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(1) << BEATS_W;
  localparam logic [CNT_W-1:0] CNT_SAT   = MAX_BEATS + CNT_W'(1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [R-1:0]       req_ready_q, req_ready_d;
  logic               res_valid_q, res_valid_d;

  logic [N-1:0][W-1:0] lanes_c;
  logic [TW-1:0]       tree_sum_c;
  logic [IDW-1:0]      pick_c;
  logic                hs_c;

  // Lane mux: only the granted requester feeds the tree.
  assign lanes_c = req_data[grant_q];

  adder_tree #(.N(N), .W(W)) u_tree (
    .lanes (lanes_c),
    .sum_c (tree_sum_c)
  );

  assign pick_c = IDW'(rr_pick(MAX_R'(req_valid), 32'(rr_ptr_q), R));
  assign hs_c   = req_valid[grant_q] & req_ready_q[grant_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    req_ready_d = '0;
    res_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d     = pick_c;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          req_ready_d = R'(1) << pick_c;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        req_ready_d = R'(1) << grant_q;
        if (hs_c) begin
          acc_d = acc_q + ACC_W'(tree_sum_c);
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          // This beat is number cnt_q+1; beyond MAX_BEATS flags overflow.
          if (cnt_q >= MAX_BEATS) ovf_d = 1'b1;
          if (req_last[grant_q]) begin
            req_ready_d = '0;
            res_valid_d = 1'b1;
            state_d     = RESULT;
          end
        end
      end
      RESULT: begin
        res_valid_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == IDW'(R - 1)) ? '0 : grant_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      req_ready_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = acc_q;
  assign res_id    = grant_q;
  assign res_ovf   = ovf_q;

endmodule
